// File: rtl/lc3_ctrl_seq_if.sv
// Sequencer-facing bundle: run/instruction inputs, stage strobes, memory-port control and status.
interface lc3_ctrl_seq_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [15:0]      instr_in;
    logic             fetch_start;
    logic             decode_start;
    logic             exec_start;
    logic             mem_start;
    logic             wb_start;
    logic             mem_sel;
    logic             mem_we;
    logic             ind_pass;
    logic [3:0]       opcode_out;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, instr_in,
        output fetch_start, decode_start, exec_start, mem_start, wb_start,
               mem_sel, mem_we, ind_pass, opcode_out, busy, halted, illegal, retired
    );

    modport slave (
        output run, instr_in,
        input  fetch_start, decode_start, exec_start, mem_start, wb_start,
               mem_sel, mem_we, ind_pass, opcode_out, busy, halted, illegal, retired
    );
endinterface

// File: rtl/lc3_ctrl_seq.sv
// LC3 instruction sequencer: walks each instruction through the stage blocks with one-cycle
// strobes, owns the shared memory port select, and tracks halt/illegal/retire status.
module lc3_ctrl_seq #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    lc3_ctrl_seq_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC,
        S_MEM, S_MWAIT, S_WB, S_NEXT, S_HALT
    } state_t;

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LD = LAT_W'(MEM_LAT - 1);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [15:0]      ir;
    logic             fetch_start, decode_start, exec_start, mem_start, wb_start;
    logic             mem_sel, mem_we, ind_pass, busy, halted, illegal;
    logic [CNT_W-1:0] retired;

    logic [3:0] op;
    logic       is_store, is_sti;
    logic       unused_ir;

    assign op        = ir[15:12];
    assign is_sti    = (op == 4'b1011);
    assign is_store  = (op == 4'b0011) || (op == 4'b0111) || is_sti;
    assign unused_ir = ^ir[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            ir           <= '0;
            fetch_start  <= 1'b0;
            decode_start <= 1'b0;
            exec_start   <= 1'b0;
            mem_start    <= 1'b0;
            wb_start     <= 1'b0;
            mem_sel      <= 1'b0;
            mem_we       <= 1'b0;
            ind_pass     <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            // Strobes are registered on entry to their state, so they last exactly one cycle.
            fetch_start  <= 1'b0;
            decode_start <= 1'b0;
            exec_start   <= 1'b0;
            mem_start    <= 1'b0;
            wb_start     <= 1'b0;
            mem_we       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state       <= S_FETCH;
                        fetch_start <= 1'b1;
                        mem_sel     <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state   <= S_FWAIT;
                    lat_cnt <= LAT_LD;
                end
                S_FWAIT: begin
                    if (lat_cnt == '0) begin
                        ir           <= bus.instr_in;
                        state        <= S_DECODE;
                        decode_start <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_DECODE: begin
                    state      <= S_EXEC;
                    exec_start <= 1'b1;
                end
                S_EXEC: begin
                    case (op)
                        4'b0010, 4'b0110: begin
                            state     <= S_MEM;
                            mem_start <= 1'b1;
                            mem_sel   <= 1'b1;
                        end
                        4'b0011, 4'b0111: begin
                            state     <= S_MEM;
                            mem_start <= 1'b1;
                            mem_sel   <= 1'b1;
                            mem_we    <= 1'b1;
                        end
                        4'b1010, 4'b1011: begin
                            state     <= S_MEM;
                            mem_start <= 1'b1;
                            mem_sel   <= 1'b1;
                            ind_pass  <= 1'b1;
                        end
                        4'b0001, 4'b0101, 4'b1001, 4'b1110, 4'b0100: begin
                            state    <= S_WB;
                            wb_start <= 1'b1;
                        end
                        4'b0000, 4'b1100: state <= S_NEXT;
                        4'b1111: begin
                            // TRAP retires here since it never reaches NEXT.
                            retired <= retired + CNT_W'(1);
                            halted  <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_HALT;
                        end
                        default: begin
                            illegal <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    state   <= S_MWAIT;
                    lat_cnt <= LAT_LD;
                end
                S_MWAIT: begin
                    if (lat_cnt == '0) begin
                        if (ind_pass) begin
                            // Pointer read done; second access is the real load/store.
                            ind_pass  <= 1'b0;
                            state     <= S_MEM;
                            mem_start <= 1'b1;
                            mem_we    <= is_sti;
                        end else if (is_store) begin
                            state <= S_NEXT;
                        end else begin
                            state    <= S_WB;
                            wb_start <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_WB: state <= S_NEXT;
                S_NEXT: begin
                    retired <= retired + CNT_W'(1);
                    if (bus.run) begin
                        state       <= S_FETCH;
                        fetch_start <= 1'b1;
                        mem_sel     <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_start  = fetch_start;
    assign bus.decode_start = decode_start;
    assign bus.exec_start   = exec_start;
    assign bus.mem_start    = mem_start;
    assign bus.wb_start     = wb_start;
    assign bus.mem_sel      = mem_sel;
    assign bus.mem_we       = mem_we;
    assign bus.ind_pass     = ind_pass;
    assign bus.opcode_out   = op;
    assign bus.busy         = busy;
    assign bus.halted       = halted;
    assign bus.illegal      = illegal;
    assign bus.retired      = retired;
endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Directed bench for lc3_ctrl_seq: per-cycle comparison against a phase-offset model of each
// instruction class, plus literal checks on fetch-to-fetch spacing and status registers.
module tb_lc3_ctrl_seq;
    localparam int L  = 2;
    localparam int CW = 3;

    typedef struct packed {
        logic          fs, ds, es, ms, ws, sel, we, ind, busy, halted, illegal;
        logic [3:0]    op;
        logic [CW-1:0] ret;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3_ctrl_seq_if #(.CNT_W(CW)) bus ();
    lc3_ctrl_seq #(.MEM_LAT(L), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      fetch_cyc[$];
    obs_t    exp_cur = '0;
    bit      exp_on = 1'b0;
    string   tag = "reset";
    logic [3:0]    prev_op = '0;
    logic [CW-1:0] base = '0;
    logic          last_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t sample();
        obs_t o;
        o.fs = bus.fetch_start;  o.ds = bus.decode_start; o.es = bus.exec_start;
        o.ms = bus.mem_start;    o.ws = bus.wb_start;     o.sel = bus.mem_sel;
        o.we = bus.mem_we;       o.ind = bus.ind_pass;    o.busy = bus.busy;
        o.halted = bus.halted;   o.illegal = bus.illegal;
        o.op = bus.opcode_out;   o.ret = bus.retired;
        return o;
    endfunction

    always @(negedge clk) begin
        obs_t act;
        act = sample();
        if (exp_on) begin
            checks++;
            if (act !== exp_cur) begin
                failures++;
                $display("FAIL cyc%0d %s: got %h want %h", cyc, tag, act, exp_cur);
            end
        end
        if (bus.fetch_start === 1'b1) fetch_cyc.push_back(cyc);
    end

    // 0 branch, 1 alu/lea/jsr, 2 store, 3 load, 4 sti, 5 ldi, 6 trap, 7 illegal
    function automatic int cls(input logic [3:0] op);
        case (op)
            4'h0, 4'hC:                   return 0;
            4'h1, 4'h5, 4'h9, 4'hE, 4'h4: return 1;
            4'h3, 4'h7:                   return 2;
            4'h2, 4'h6:                   return 3;
            4'hB:                         return 4;
            4'hA:                         return 5;
            4'hF:                         return 6;
            default:                      return 7;
        endcase
    endfunction

    function automatic int ilen(input int c);
        case (c)
            0:       return L + 4;
            1:       return L + 5;
            2:       return 2 * L + 5;
            3:       return 2 * L + 6;
            4:       return 3 * L + 6;
            5:       return 3 * L + 7;
            default: return L + 3 + 4;
        endcase
    endfunction

    // Expected outputs k cycles after the instruction's fetch cycle.
    function automatic obs_t model(input logic [3:0] op, input int k,
                                   input logic [3:0] pop, input logic [CW-1:0] b);
        obs_t o;
        int c;
        c = cls(op);
        o = '0;
        o.busy = 1'b1;
        o.ret  = b;
        o.op   = (k >= L + 1) ? op : pop;
        o.fs   = (k == 0);
        o.ds   = (k == L + 1);
        o.es   = (k == L + 2);
        if (c >= 2 && c <= 5) begin
            o.sel = (k >= L + 3);
            o.ms  = (k == L + 3) || (c >= 4 && k == 2 * L + 4);
            o.ind = (c >= 4) && (k >= L + 3) && (k <= 2 * L + 3);
            o.we  = (c == 2 && k == L + 3) || (c == 4 && k == 2 * L + 4);
        end
        o.ws = (c == 1 && k == L + 3) || (c == 3 && k == 2 * L + 4) || (c == 5 && k == 3 * L + 5);
        if (c >= 6 && k >= L + 3) begin
            o.busy    = 1'b0;
            o.halted  = (c == 6);
            o.illegal = (c == 7);
            if (c == 6) o.ret = b + CW'(1);
        end
        return o;
    endfunction

    function automatic obs_t idle_model();
        obs_t o;
        o = '0;
        o.op  = prev_op;
        o.sel = last_sel;
        o.ret = base;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        tag = "reset";
        rst = 1'b1;
        exp_on = 1'b0;
        tick();
        repeat (5) begin
            exp_cur = '0;
            exp_on  = 1'b1;
            tick();
        end
        rst = 1'b0;
        exp_cur = '0;
        tick();
        prev_op = '0;
        base = '0;
        last_sel = 1'b0;
    endtask

    task automatic do_instr(input logic [15:0] ins, input int cut, input bit drop, input string name);
        int c, n;
        c = cls(ins[15:12]);
        n = (cut >= 0) ? cut : ilen(c);
        bus.instr_in = ins;
        tag = name;
        for (int k = 0; k < n; k++) begin
            exp_cur = model(ins[15:12], k, prev_op, base);
            exp_on  = 1'b1;
            if (drop && k == L + 2) bus.run = 1'b0;
            tick();
        end
        if (cut < 0) begin
            if (c <= 6) base = base + CW'(1);
            last_sel = (c >= 2 && c <= 5);
            prev_op  = ins[15:12];
        end
    endtask

    task automatic do_idle(input int n);
        tag = "idle";
        for (int i = 0; i < n; i++) begin
            exp_cur = idle_model();
            exp_on  = 1'b1;
            tick();
        end
    endtask

    initial begin
        int want_d[8];
        want_d = '{7, 10, 12, 13, 9, 6, 6, 7};
        bus.run = 1'b1;
        bus.instr_in = 16'h0000;

        do_reset();
        do_instr(16'h1021, -1, 1'b0, "add");
        do_instr(16'h6042, -1, 1'b0, "ldr");
        do_instr(16'hB600, -1, 1'b0, "sti");
        do_instr(16'hA400, -1, 1'b0, "ldi");
        do_instr(16'h3200, -1, 1'b0, "st");
        do_instr(16'h0000, -1, 1'b0, "br");
        do_instr(16'hC1C0, -1, 1'b0, "jmp");
        do_instr(16'h5000, -1, 1'b0, "and");
        do_instr(16'h1021, -1, 1'b1, "add_stop");
        chk("retired_wrap", int'(bus.retired), 1);
        chk("idle_busy", int'(bus.busy), 0);
        do_idle(3);
        bus.run = 1'b1;
        do_idle(1);
        do_instr(16'h903F, -1, 1'b0, "not");
        do_instr(16'hF025, -1, 1'b0, "trap");
        chk("trap_halted", int'(bus.halted), 1);
        chk("trap_retired", int'(bus.retired), 3);

        if (fetch_cyc.size() < 9) begin
            failures++;
            $display("FAIL fetch_count: got %0d want >=9", fetch_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("cpi_%0d", i), fetch_cyc[i+1] - fetch_cyc[i], want_d[i]);
        end

        do_reset();
        do_instr(16'h6042, 5, 1'b0, "ldr_abort");
        do_reset();
        do_instr(16'h8000, -1, 1'b0, "rti");
        chk("rti_illegal", int'(bus.illegal), 1);
        chk("rti_retired", int'(bus.retired), 0);
        chk("rti_halted", int'(bus.halted), 0);
        do_reset();
        do_instr(16'hD000, -1, 1'b0, "reserved");
        chk("rsv_illegal", int'(bus.illegal), 1);
        do_reset();
        chk("final_illegal", int'(bus.illegal), 0);

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end
endmodule

// File: doc/lc3_ctrl_seq.md
Name: lc3_ctrl_seq

Overview:
Top-level instruction sequencer for the LC3 core. Steps each instruction through fetch, decode, execute, memory and writeback phases by pulsing the start strobes of the existing stage blocks (fetch_start into fetch, and the equivalents for the other stages). Arbitrates the single memory port between instruction fetch and data access. Handles two-access indirect ops (LDI/STI), stops on TRAP or an illegal opcode, and counts retired instructions.

Parameters:
MEM_LAT, 2, memory read latency in cycles, from address valid to data valid (must be >=1)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  level; 1 = keep executing, 0 = stop after the current instruction retires
instr_in  input  16  memory read data; sampled as the instruction on the last FWAIT cycle
fetch_start  output  1  one-cycle strobe to the fetch stage
decode_start  output  1  one-cycle strobe to the decode stage
exec_start  output  1  one-cycle strobe to the execute stage
mem_start  output  1  one-cycle strobe for a data access
wb_start  output  1  one-cycle strobe for register writeback
mem_sel  output  1  memory port owner: 0 = fetch address, 1 = data address
mem_we  output  1  data write enable, asserted only with mem_start on the final store access
ind_pass  output  1  1 during the pointer-read access of LDI/STI
opcode_out  output  4  IR[15:12] of the current instruction
busy  output  1  1 in every state except IDLE and HALT
halted  output  1  sticky; set when TRAP (1111) retires
illegal  output  1  sticky; set on RTI (1000) or reserved (1101)
retired  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything.
  - All strobes 0, mem_sel=0, mem_we=0, ind_pass=0, opcode_out=0, busy=0, halted=0, illegal=0, retired=0.
  - IR cleared, state=IDLE.
  - Reset mid-instruction abandons the instruction with no strobe in the following cycle.
- States: IDLE, FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, NEXT, HALT.
- IDLE: if run=1 -> FETCH.
- FETCH (1 cycle): fetch_start=1, mem_sel=0 -> FWAIT. The latency counter loads MEM_LAT-1.
- FWAIT (exactly MEM_LAT cycles): mem_sel=0. When the counter reaches 0, IR<=instr_in -> DECODE.
- DECODE (1 cycle): decode_start=1. opcode_out is valid from this cycle until the next FETCH.
- EXEC (1 cycle): exec_start=1. Next state by opcode:
  - LD 0010, LDR 0110, ST 0011, STR 0111 -> MEM.
  - LDI 1010, STI 1011 -> MEM with ind_pass=1.
  - ADD 0001, AND 0101, NOT 1001, LEA 1110, JSR 0100 -> WB.
  - BR 0000, JMP 1100 -> NEXT.
  - TRAP 1111 -> retired+1, halted<=1 -> HALT.
  - 1000 / 1101 -> illegal<=1 -> HALT, with no retire.
- MEM (1 cycle): mem_start=1, mem_sel=1. mem_we=1 only for ST/STR, or STI with ind_pass=0. Counter loads MEM_LAT-1 -> MWAIT.
- MWAIT (MEM_LAT cycles): mem_sel=1. At count 0:
  - if ind_pass=1: clear it -> MEM (second access);
  - else loads -> WB, stores -> NEXT.
- A store's write completes on the MEM edge, but MWAIT still lasts MEM_LAT cycles to keep timing uniform.
- WB (1 cycle): wb_start=1 -> NEXT.
- NEXT (1 cycle, no strobes): retired <= retired+1 (wraps); if run=1 -> FETCH, else -> IDLE.
- HALT: all strobes 0, busy=0. Only rst leaves HALT; run is ignored.
- At most one strobe is high in any cycle. mem_sel changes only in FETCH or MEM.
- run falling mid-instruction has no effect until NEXT. run toggling in IDLE is sampled every cycle.
- Cycles per instruction (FETCH edge to next FETCH edge, run held 1) = 3 + MEM_LAT + k:
  - k=1 for BR/JMP;
  - k=2 for ALU, LEA, JSR;
  - k=2+MEM_LAT for stores;
  - k=3+MEM_LAT for loads;
  - add 1+MEM_LAT for LDI/STI.
- With MEM_LAT=2: BR 6, ADD 7, ST 9, LDR 10, LDI 13, STI 12.

Test Plan:
1. Reset hold 5 cycles with run=1, then release -> all outputs 0 through reset; the cycle after release: FETCH, fetch_start=1, mem_sel=0.
2. instr_in=x1021 (ADD), MEM_LAT=2, run held 1 -> strobe order fetch, decode(cyc 3), exec(4), wb(5), fetch again at cyc 7; retired=1; mem_start never asserted.
3. instr_in=x6042 (LDR) -> mem_start at cycle 5 with mem_sel=1, mem_we=0; wb_start at cycle 8; retired increments after 10 cycles.
4. instr_in=xB600 (STI) -> two mem_start pulses 3 cycles apart; first has ind_pass=1, mem_we=0; second has mem_we=1; no wb_start; 12 cycles total.
5. run dropped during the EXEC of an ADD -> WB still pulses, retired+1, state IDLE, busy=0, no further fetch_start; run=1 again -> fetch_start the next cycle.
6. instr_in=xF025 -> halted=1, retired+1, no strobes afterwards even with run=1; then instr x8000 after reset -> illegal=1, retired unchanged (0); rst clears both.
